// File: rtl/dlx_mem_pkg.sv
// Shared encodings for the DLX memory arbiter: access sizes, FSM states,
// grant owners and the access-legality helper.
package dlx_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  typedef enum logic {
    GR_INSTR = 1'b0,
    GR_DATA  = 1'b1
  } grant_e;

  // A data access is rejected when misaligned for its size or when the size is illegal.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] a);
    logic e;
    e = 1'b0;
    case (size)
      SZ_BYTE: e = 1'b0;
      SZ_HALF: e = a[0];
      SZ_WORD: e = (a != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dlx_lane_align.sv
// Big-endian lane steering: load extract/extend and byte/half store merge.
// Byte lane 0 is bits [0:7]; store data arrives right-aligned.
module dlx_lane_align
  import dlx_mem_pkg::*;
(
  input  logic [0:31] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [0:31] wdata_i,
  output logic [0:31] rdata_o,
  output logic [0:31] merged_o
);

  logic [0:7]  byte_s;
  logic [0:15] half_s;

  // Select the addressed lane and right-align it with sign or zero fill.
  always_comb begin
    byte_s  = 8'h00;
    half_s  = 16'h0000;
    rdata_o = word_i;
    case (addr_i)
      2'd0:    byte_s = word_i[0:7];
      2'd1:    byte_s = word_i[8:15];
      2'd2:    byte_s = word_i[16:23];
      2'd3:    byte_s = word_i[24:31];
      default: byte_s = 8'h00;
    endcase
    if (addr_i[1]) begin
      half_s = word_i[16:31];
    end else begin
      half_s = word_i[0:15];
    end
    case (size_i)
      SZ_BYTE: rdata_o = {{24{signed_i & byte_s[0]}}, byte_s};
      SZ_HALF: rdata_o = {{16{signed_i & half_s[0]}}, half_s};
      default: rdata_o = word_i;
    endcase
  end

  // Overlay the right-aligned store data onto the addressed lane of the old word.
  always_comb begin
    merged_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        case (addr_i)
          2'd0:    merged_o[0:7]   = wdata_i[24:31];
          2'd1:    merged_o[8:15]  = wdata_i[24:31];
          2'd2:    merged_o[16:23] = wdata_i[24:31];
          2'd3:    merged_o[24:31] = wdata_i[24:31];
          default: merged_o = word_i;
        endcase
      end
      SZ_HALF: begin
        if (addr_i[1]) begin
          merged_o[16:31] = wdata_i[16:31];
        end else begin
          merged_o[0:15] = wdata_i[16:31];
        end
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dlx_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported SRAM between instruction
// fetch and MEM-stage load/store. Sub-word stores use read-modify-write.
module dlx_mem_arbiter
  import dlx_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [0:DW-1] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic          d_signed,
  input  logic [AW-1:0] d_addr,
  input  logic [0:DW-1] d_wdata,
  output logic          d_ack,
  output logic [0:DW-1] d_rdata,
  output logic          d_err,
  output logic          sram_cs,
  output logic          sram_oe,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [0:DW-1] sram_din,
  input  logic [0:DW-1] sram_dout
);

  state_e        state_q, state_d;
  grant_e        last_grant_q, last_grant_d;
  grant_e        grant_q, grant_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          we_q, we_d;
  logic          signed_q, signed_d;
  logic [0:DW-1] wdata_q, wdata_d;
  logic [0:DW-1] merged_q, merged_d;
  logic          i_ack_q, i_ack_d;
  logic [0:DW-1] i_rdata_q, i_rdata_d;
  logic          d_ack_q, d_ack_d;
  logic [0:DW-1] d_rdata_q, d_rdata_d;
  logic          d_err_q, d_err_d;
  logic          pick_data_s;
  logic [0:DW-1] align_rdata_s;
  logic [0:DW-1] align_merged_s;

  dlx_lane_align u_align (
    .word_i   (sram_dout),
    .addr_i   (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .rdata_o  (align_rdata_s),
    .merged_o (align_merged_s)
  );

  // Next-state, arbitration, request latching and response registers.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    size_d       = size_q;
    we_d         = we_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    merged_d     = merged_q;
    i_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_ack_d      = 1'b0;
    d_rdata_d    = d_rdata_q;
    d_err_d      = 1'b0;
    // Data wins when alone, or on contention when instruction was served last.
    pick_data_s  = d_req && (!i_req || (last_grant_q == GR_INSTR));
    case (state_q)
      ST_IDLE: begin
        if (pick_data_s) begin
          grant_d  = GR_DATA;
          addr_d   = d_addr;
          size_d   = d_size;
          we_d     = d_we;
          signed_d = d_signed;
          wdata_d  = d_wdata;
          if (access_err(d_size, d_addr[1:0])) begin
            state_d = ST_RESP;
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
          end else if (d_we && (d_size != SZ_WORD)) begin
            state_d = ST_RMW_RD;
          end else begin
            state_d = ST_ACCESS;
          end
        end else if (i_req) begin
          grant_d  = GR_INSTR;
          addr_d   = i_addr;
          size_d   = SZ_WORD;
          we_d     = 1'b0;
          signed_d = 1'b0;
          state_d  = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (grant_q == GR_INSTR) begin
          i_ack_d   = 1'b1;
          i_rdata_d = sram_dout;
        end else begin
          d_ack_d = 1'b1;
          if (!we_q) begin
            d_rdata_d = align_rdata_s;
          end else begin
            d_rdata_d = d_rdata_q;
          end
        end
      end
      ST_RMW_RD: begin
        merged_d = align_merged_s;
        state_d  = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        d_ack_d = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and favours data next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GR_INSTR;
      grant_q      <= GR_INSTR;
      addr_q       <= '0;
      size_q       <= 2'b00;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      merged_q     <= '0;
      i_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_ack_q      <= 1'b0;
      d_rdata_q    <= '0;
      d_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      we_q         <= we_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      merged_q     <= merged_d;
      i_ack_q      <= i_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_ack_q      <= d_ack_d;
      d_rdata_q    <= d_rdata_d;
      d_err_q      <= d_err_d;
    end
  end

  // SRAM strobes decode from state and latched request only, so they drop with reset.
  always_comb begin
    sram_cs  = 1'b0;
    sram_oe  = 1'b0;
    sram_we  = 1'b0;
    sram_din = '0;
    case (state_q)
      ST_ACCESS: begin
        sram_cs = 1'b1;
        if (we_q) begin
          sram_we  = 1'b1;
          sram_din = wdata_q;
        end else begin
          sram_oe = 1'b1;
        end
      end
      ST_RMW_RD: begin
        sram_cs = 1'b1;
        sram_oe = 1'b1;
      end
      ST_RMW_WR: begin
        sram_cs  = 1'b1;
        sram_we  = 1'b1;
        sram_din = merged_q;
      end
      default: begin
        sram_cs = 1'b0;
      end
    endcase
  end

  assign sram_addr = {addr_q[AW-1:2], 2'b00};
  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Self-checking bench for dlx_mem_arbiter with a behavioural SRAM and a
// queue of expected responses.
module tb_dlx_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [0:31] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_signed;
  logic [31:0] d_addr;
  logic [0:31] d_wdata;
  logic        d_ack;
  logic [0:31] d_rdata;
  logic        d_err;
  logic        sram_cs, sram_oe, sram_we;
  logic [31:0] sram_addr;
  logic [0:31] sram_din;
  logic [0:31] sram_dout;

  always #5 clk = ~clk;

  dlx_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  logic [0:31] mem [0:255];
  assign sram_dout = mem[sram_addr[9:2]];

  always @(posedge clk) begin
    if (sram_cs && sram_we) mem[sram_addr[9:2]] <= sram_din;
  end

  typedef struct {
    logic        is_i;
    logic [0:31] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  logic        tr_cs [0:20];
  logic        tr_oe [0:20];
  logic        tr_we [0:20];
  logic [31:0] tr_addr [0:20];
  logic [0:31] tr_din [0:20];
  logic        proto_bad;
  logic [0:31] obs_rdata;
  logic        obs_err;

  // Waits one cycle to reach IDLE, drives one request and follows it to its ack.
  task automatic run_txn(input logic is_i, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [0:31] wd,
                         output int lat);
    @(posedge clk); #1;
    if (is_i) begin
      i_req = 1'b1; i_addr = a;
    end else begin
      d_req = 1'b1; d_we = we; d_size = sz; d_signed = sg; d_addr = a; d_wdata = wd;
    end
    lat = -1;
    proto_bad = 1'b0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk); #1;
      tr_cs[c] = sram_cs; tr_oe[c] = sram_oe; tr_we[c] = sram_we;
      tr_addr[c] = sram_addr; tr_din[c] = sram_din;
      if (sram_oe && sram_we) proto_bad = 1'b1;
      if (is_i ? i_ack : d_ack) begin
        lat = c;
        obs_rdata = is_i ? i_rdata : d_rdata;
        obs_err = d_err;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_size = 2'b00; d_signed = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    mem[0]  <= 32'h2001AAAA;
    mem[32] <= 32'hF0F077F0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({i_ack, d_ack, d_err, sram_cs, sram_oe, sram_we} !== 6'b0)
      begin failures++; $display("FAIL reset_ctrl got=%b want=000000", {i_ack, d_ack, d_err, sram_cs, sram_oe, sram_we}); end
    checks++;
    if (i_rdata !== 32'h0 || d_rdata !== 32'h0)
      begin failures++; $display("FAIL reset_rdata got i=%h d=%h want 0", i_rdata, d_rdata); end
    checks++;
    if (sram_addr !== 32'h0 || sram_din !== 32'h0)
      begin failures++; $display("FAIL reset_sram got addr=%h din=%h want 0", sram_addr, sram_din); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  // Both requesters held: first contention after reset goes to data, then alternates.
  task automatic test_contention;
    exp_t e;
    int   got;
    sb.push_back('{1'b0, 32'hF0F077F0, 1'b0, 2});
    sb.push_back('{1'b1, 32'h2001AAAA, 1'b0, 5});
    sb.push_back('{1'b0, 32'hF0F077F0, 1'b0, 8});
    sb.push_back('{1'b1, 32'h2001AAAA, 1'b0, 11});
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_signed = 1'b0; d_addr = 32'h80; d_wdata = 32'h0;
    for (int c = 1; c <= 40 && sb.size() > 0; c++) begin
      @(posedge clk); #1;
      if (i_ack && d_ack) begin
        checks++; failures++; $display("FAIL rr_both_ack cycle=%0d", c);
      end else if (i_ack || d_ack) begin
        e = sb.pop_front();
        got = i_ack ? 1 : 0;
        checks++;
        if (i_ack !== e.is_i || c != e.lat)
          begin failures++; $display("FAIL rr_order got instr=%0d cycle=%0d want instr=%0d cycle=%0d", got, c, e.is_i, e.lat); end
        checks++;
        if ((i_ack ? i_rdata : d_rdata) !== e.rdata)
          begin failures++; $display("FAIL rr_data got=%h want=%h", (i_ack ? i_rdata : d_rdata), e.rdata); end
      end
    end
    if (sb.size() > 0) begin
      checks++; failures++;
      $display("FAIL rr_timeout pending=%0d want 0", sb.size());
      sb.delete();
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_fetch;
    exp_t e;
    int   lat;
    logic [31:0] fa [2];
    fa[0] = 32'h0; fa[1] = 32'h3;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{1'b1, 32'h2001AAAA, 1'b0, 2});
      run_txn(1'b1, 1'b0, 2'b10, 1'b0, fa[k], 32'h0, lat);
      e = sb.pop_front();
      checks++;
      if (lat != e.lat || obs_rdata !== e.rdata)
        begin failures++; $display("FAIL fetch%0d got lat=%0d data=%h want lat=%0d data=%h", k, lat, obs_rdata, e.lat, e.rdata); end
      checks++;
      if (tr_oe[1] !== 1'b1 || tr_we[1] !== 1'b0 || tr_addr[1] !== 32'h0 || tr_cs[2] !== 1'b0 || tr_oe[2] !== 1'b0)
        begin failures++; $display("FAIL fetch_bus%0d got oe1=%b we1=%b addr1=%h cs2=%b want 1 0 0 0", k, tr_oe[1], tr_we[1], tr_addr[1], tr_cs[2]); end
    end
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [0:31] exp;
  } ld_t;

  task automatic test_load_extract;
    ld_t  tbl [6];
    exp_t e;
    int   lat;
    tbl[0] = '{2'b00, 1'b0, 32'h80, 32'h000000F0};
    tbl[1] = '{2'b00, 1'b1, 32'h80, 32'hFFFFFFF0};
    tbl[2] = '{2'b01, 1'b1, 32'h82, 32'h000077F0};
    tbl[3] = '{2'b01, 1'b1, 32'h80, 32'hFFFFF0F0};
    tbl[4] = '{2'b00, 1'b1, 32'h82, 32'h00000077};
    tbl[5] = '{2'b01, 1'b0, 32'h80, 32'h0000F0F0};
    for (int k = 0; k < 6; k++) begin
      sb.push_back('{1'b0, tbl[k].exp, 1'b0, 2});
      run_txn(1'b0, 1'b0, tbl[k].sz, tbl[k].sg, tbl[k].a, 32'h0, lat);
      e = sb.pop_front();
      checks++;
      if (lat != e.lat || obs_rdata !== e.rdata || obs_err !== e.err)
        begin failures++; $display("FAIL load%0d got lat=%0d data=%h err=%b want lat=%0d data=%h err=%b", k, lat, obs_rdata, obs_err, e.lat, e.rdata, e.err); end
    end
  endtask

  task automatic test_store_rmw;
    exp_t e;
    int   lat;
    // Byte store into lane 1
    sb.push_back('{1'b0, 32'hF0AA77F0, 1'b0, 3});
    run_txn(1'b0, 1'b1, 2'b00, 1'b0, 32'h81, 32'h000000AA, lat);
    e = sb.pop_front();
    checks++;
    if (lat != e.lat) begin failures++; $display("FAIL sb_lat got=%0d want=%0d", lat, e.lat); end
    checks++;
    if (tr_oe[1] !== 1'b1 || tr_we[1] !== 1'b0 || tr_we[2] !== 1'b1 || tr_oe[2] !== 1'b0 || tr_din[2] !== e.rdata)
      begin failures++; $display("FAIL sb_bus got oe1=%b we1=%b we2=%b oe2=%b din2=%h want 1 0 1 0 %h", tr_oe[1], tr_we[1], tr_we[2], tr_oe[2], tr_din[2], e.rdata); end
    checks++;
    if (mem[32] !== e.rdata) begin failures++; $display("FAIL sb_mem got=%h want=%h", mem[32], e.rdata); end
    sb.push_back('{1'b0, 32'hF0AA77F0, 1'b0, 2});
    run_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, lat);
    e = sb.pop_front();
    checks++;
    if (lat != e.lat || obs_rdata !== e.rdata)
      begin failures++; $display("FAIL sb_readback got lat=%0d data=%h want lat=%0d data=%h", lat, obs_rdata, e.lat, e.rdata); end
    // Half store into the low half
    sb.push_back('{1'b0, 32'hF0AA1234, 1'b0, 3});
    run_txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h82, 32'hDEAD1234, lat);
    e = sb.pop_front();
    checks++;
    if (lat != e.lat || tr_din[2] !== e.rdata || mem[32] !== e.rdata)
      begin failures++; $display("FAIL sh got lat=%0d din2=%h mem=%h want lat=%0d %h", lat, tr_din[2], mem[32], e.lat, e.rdata); end
    // Word store takes the single-cycle path
    sb.push_back('{1'b0, 32'h11223344, 1'b0, 2});
    run_txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h84, 32'h11223344, lat);
    e = sb.pop_front();
    checks++;
    if (lat != e.lat || tr_we[1] !== 1'b1 || tr_oe[1] !== 1'b0 || tr_din[1] !== e.rdata || mem[33] !== e.rdata)
      begin failures++; $display("FAIL sw got lat=%0d we1=%b din1=%h mem=%h want lat=%0d 1 %h", lat, tr_we[1], tr_din[1], mem[33], e.lat, e.rdata); end
    checks++;
    if (proto_bad !== 1'b0) begin failures++; $display("FAIL oe_we_overlap got=%b want=0", proto_bad); end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] a;
  } er_t;

  task automatic test_errors;
    er_t  tbl [4];
    exp_t e;
    int   lat;
    tbl[0] = '{1'b0, 2'b10, 32'h82};
    tbl[1] = '{1'b0, 2'b11, 32'h80};
    tbl[2] = '{1'b0, 2'b01, 32'h81};
    tbl[3] = '{1'b1, 2'b01, 32'h83};
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{1'b0, 32'h0, 1'b1, 1});
      run_txn(1'b0, tbl[k].we, tbl[k].sz, 1'b0, tbl[k].a, 32'hFFFFFFFF, lat);
      e = sb.pop_front();
      checks++;
      if (lat != e.lat || obs_err !== e.err)
        begin failures++; $display("FAIL err%0d got lat=%0d err=%b want lat=%0d err=1", k, lat, obs_err, e.lat); end
      checks++;
      if (tr_cs[1] !== 1'b0) begin failures++; $display("FAIL err_cs%0d got=%b want=0", k, tr_cs[1]); end
    end
    checks++;
    if (mem[32] !== 32'hF0AA1234) begin failures++; $display("FAIL err_mem got=%h want=F0AA1234", mem[32]); end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_signed = 1'b0; d_addr = 32'h81; d_wdata = 32'h00000055;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sram_we !== 1'b1) begin failures++; $display("FAIL rmw_wr_we got=%b want=1", sram_we); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sram_cs, sram_oe, sram_we, i_ack, d_ack, d_err} !== 6'b0 || d_rdata !== 32'h0 || sram_din !== 32'h0)
      begin failures++; $display("FAIL midrst_out got=%b din=%h want 000000 0", {sram_cs, sram_oe, sram_we, i_ack, d_ack, d_err}, sram_din); end
    @(posedge clk); #1;
    checks++;
    if (mem[32] !== 32'hF0AA1234 || d_ack !== 1'b0)
      begin failures++; $display("FAIL midrst_mem got=%h ack=%b want F0AA1234 0", mem[32], d_ack); end
    @(negedge clk) rst_n = 1'b1;
    sb.push_back('{1'b0, 32'hF0551234, 1'b0, 3});
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (d_ack) lat = c;
    end
    d_req = 1'b0;
    begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (lat != e.lat || mem[32] !== e.rdata)
        begin failures++; $display("FAIL midrst_retry got lat=%0d mem=%h want lat=%0d mem=%h", lat, mem[32], e.lat, e.rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_fetch();
    test_load_extract();
    test_store_rmw();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dlx_mem_arbiter.md
# dlx_mem_arbiter

Sequential arbiter and access controller that shares the single-ported `sram` between the DLX instruction-fetch port and the MEM-stage load/store port.

- Grants one requester at a time using round-robin.
- Drives the SRAM's `cs`/`oe`/`we`/`addr`/`din` and captures `dout`.
- Performs byte and halfword load extraction with sign or zero extension.
- The SRAM has no byte enables, so byte and halfword stores are done as read-modify-write.
- All data buses use the codebase's big-endian `[0:31]` ordering: bit 0 is the MSB, and byte lane 0 is bits `[0:7]`.

## Interface

Parameters:
- `AW`, default 32: address width.
- `DW`, default 32: data width. Fixed at 32 for this revision.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  instruction fetch request. Held until `i_ack`.
- `i_addr`  in  32  fetch address. Must be word-aligned and stable while `i_req` is high.
- `i_ack`  out  1  one-cycle pulse; `i_rdata` is valid in this cycle.
- `i_rdata`  out  `[0:31]`  fetched word.
- `d_req`  in  1  data request. Held until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `d_signed`  in  1  sign-extend loads.
- `d_addr`  in  32  byte address.
- `d_wdata`  in  `[0:31]`  store data, right-aligned (byte in `[24:31]`, half in `[16:31]`).
- `d_ack`  out  1  one-cycle completion pulse.
- `d_rdata`  out  `[0:31]`  load result, right-aligned and extended.
- `d_err`  out  1  valid with `d_ack`; misaligned access or illegal size.
- `sram_cs`, `sram_oe`, `sram_we`  out  1 each  SRAM controls.
- `sram_addr`  out  32  word address; bits `[1:0]` are always 0.
- `sram_din`  out  `[0:31]`  SRAM write data.
- `sram_dout`  in  `[0:31]`  SRAM read data. Combinational and valid in the same cycle as `addr`/`oe`.

## Operation

States: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.

- **Reset:** state = IDLE, `last_grant` = INSTR, all outputs and data registers = 0.
- **IDLE — arbitration:**
  - Only `i_req` pending: grant instruction.
  - Only `d_req` pending: grant data.
  - Both pending: grant the side opposite `last_grant`. The first contention after reset therefore goes to data.
  - The grantee's address, size, data and control are latched into registers.
- **IDLE — next state for a data grant:**
  - Misaligned (half with `addr[0]`=1, or word with `addr[1:0]`≠0) or `d_size`=11: go to RESP with `d_err`=1. No SRAM access.
  - Byte or half store: go to RMW_RD.
  - Otherwise: go to ACCESS.
- **IDLE — instruction grants** always go to ACCESS. A misaligned `i_addr` has its low bits ignored (forced to 0).
- **ACCESS:** `cs`=1.
  - Load or fetch: `oe`=1; `sram_dout` is captured, extracted and extended at the edge.
  - Word store: `we`=1 and `din` = `wdata`.
  - Next state: RESP.
- **RMW_RD:** `cs`=1, `oe`=1. The word is captured, and the new byte/half is merged into lane `addr[1:0]`. Next state: RMW_WR.
- **RMW_WR:** `cs`=1, `we`=1, `din` = merged word. Next state: RESP.
- **RESP:** the grantee's ack is high for exactly one cycle and data is valid. `last_grant` is updated. Requests are not sampled in this state. Next state: IDLE.
- **Load extraction:**
  - Byte: lane `addr[1:0]` (lane 0 = bits `[0:7]`).
  - Half: `addr[1]`=0 selects `[0:15]`; `addr[1]`=1 selects `[16:31]`.
  - Upper bits are zero-filled, or filled with the sign bit when `d_signed`=1.
- **Reset mid-transaction:** `sram_we`/`cs`/`oe` drop immediately (asynchronous), no ack is issued, and the pending request is re-arbitrated after reset.

## Timing

Cycle 0 is the IDLE cycle in which the request is sampled.

- Error response: ack in cycle 1.
- Word read, fetch, or word store: ACCESS in cycle 1, ack in cycle 2.
- Byte or half store: RMW_RD in cycle 1, RMW_WR in cycle 2, ack in cycle 3. The SRAM write commits at the end of cycle 2.
- A requester may raise a new request in the cycle after its ack; the earliest re-grant is therefore one cycle after RESP.
- `sram_cs`/`oe`/`we` are driven only in ACCESS, RMW_RD and RMW_WR. They are never high in IDLE or RESP, and `oe` and `we` are never both high.
- Outputs are registered, except SRAM controls, which decode directly from state plus latched request registers (glitch-free, no input-to-output combinational path).

## Structure

- **Shared package `dlx_mem_pkg`:**
  - Size encodings: `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - State encodings.
  - Grant encodings: `GR_INSTR`, `GR_DATA`.
- **Sub-module `dlx_lane_align`:** purely combinational; performs load extract/extend and store merge. Inputs: word, `addr[1:0]`, size, signed, `wdata`. Outputs: `rdata`, merged word.
- **Top:** FSM, arbiter, and request latches.

## Test plan

SRAM word 0x80 preloaded with 0xF0F077F0.

1. Word fetch of 0x00 containing 0x2001AAAA → `i_ack` in cycle 2 with `i_rdata`=0x2001AAAA; `sram_addr`=0x00 and `oe`=1 only in cycle 1.
2. Load byte 0x80 → unsigned gives `d_rdata`=0x000000F0; signed gives 0xFFFFFFF0. Load half 0x82, signed → 0x000077F0.
3. Store byte 0x81 with `d_wdata`=0x000000AA → read in cycle 1, `we` with `din`=0xF0AA77F0 in cycle 2, `d_ack` in cycle 3; a following word load of 0x80 returns 0xF0AA77F0.
4. `i_req` and `d_req` held continuously → grants alternate D, I, D, I; neither requester waits for more than one other transaction.
5. Word load of 0x82, and a request with `d_size`=11 → each gives `d_ack`=1 and `d_err`=1 in cycle 1, with `sram_cs` never asserted.
6. `rst_n` pulled low during RMW_WR → `sram_we` falls immediately, no `d_ack`, SRAM word unchanged, all outputs 0, and the held request is serviced normally after release.
